// File: rtl/fcvt_s_w_if.sv
// Operand/result bundle for the int32 -> binary32 converter.
// x: signed integer operand; y: registered float result.
interface fcvt_s_w_if;
    logic [31:0] x;
    logic [31:0] y;

    modport master (
        output x,
        input  y
    );

    modport slave (
        input  x,
        output y
    );
endinterface

// File: rtl/fcvt_s_w.sv
// FCVT.S.W: signed int32 to IEEE-754 single, RNE, 1-cycle latency.
// Ports: clk, rstn (async active-low), bus.x operand, bus.y result.
module fcvt_s_w (
    input  logic       clk,
    input  logic       rstn,
    fcvt_s_w_if.slave  bus
);

    logic        w_s;
    logic [31:0] w_m;
    logic [4:0]  w_p;
    logic [31:0] w_n;
    logic        w_g;
    logic        w_st;
    logic        w_inc;
    logic [23:0] w_fr;
    logic [7:0]  w_e;
    logic [31:0] w_y;
    logic [31:0] r_y;

    always_comb begin
        w_s = bus.x[31];
        // 0x8000_0000 negates to itself, which read unsigned is 2^31
        w_m = w_s ? (~bus.x + 32'd1) : bus.x;
        // priority encoder: highest set bit wins
        w_p = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (w_m[i]) begin
                w_p = 5'(i);
            end
        end
        w_n   = w_m << (5'd31 - w_p);
        w_g   = w_n[7];
        w_st  = |w_n[6:0];
        w_inc = w_g & (w_st | w_n[8]);
        // carry into bit 23 means the fraction wrapped to zero
        w_fr  = {1'b0, w_n[30:8]} + {23'd0, w_inc};
        w_e   = 8'd127 + {3'd0, w_p} + {7'd0, w_fr[23]};
        w_y   = (w_m == 32'd0) ? 32'd0 : {w_s, w_e, w_fr[22:0]};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_y <= 32'd0;
        end else begin
            r_y <= w_y;
        end
    end

    assign bus.y = r_y;

endmodule

// File: tb/tb_fcvt_s_w.sv
// Scoreboard bench for fcvt_s_w: directed vectors plus a random stream.
// Expected values are queued at issue and popped by a monitor.
module tb_fcvt_s_w;

    logic clk;
    logic rstn;
    fcvt_s_w_if bus ();

    fcvt_s_w dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] in_q  [$];

    function automatic logic [31:0] model(input logic [31:0] v);
        longint m, q, r, half;
        int p, sh, e;
        logic s;
        logic [31:0] res;
        if (v == 32'd0) return 32'd0;
        s = v[31];
        m = s ? (longint'(64'h1_0000_0000) - longint'(v)) : longint'(v);
        p = 0;
        for (int i = 31; i >= 0; i--) begin
            if (((m >> i) & 1) == 1) begin
                p = i;
                break;
            end
        end
        e = 127 + p;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (r > half || (r == half && (q & 1) == 1)) q = q + 1;
            if (q == (longint'(1) << 24)) begin
                q = longint'(1) << 23;
                e = e + 1;
            end
        end
        res = {s, 8'(e), 23'(q)};
        return res;
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, req);
        end
    endtask

    task automatic issue(input logic [31:0] v, input logic [31:0] e);
        @(negedge clk);
        bus.x = v;
        in_q.push_back(v);
        exp_q.push_back(e);
    endtask

    // monitor: one result per edge after each issued operand
    always begin
        logic [31:0] e, v;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            v = in_q.pop_front();
            check($sformatf("conv x=%h", v), bus.y, e);
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
    endtask

    logic [31:0] dv [12];
    logic [31:0] de [12];

    initial begin
        dv[0]  = 32'd1;          de[0]  = 32'h3F80_0000;
        dv[1]  = 32'hFFFF_FFFF;  de[1]  = 32'hBF80_0000;
        dv[2]  = 32'd2;          de[2]  = 32'h4000_0000;
        dv[3]  = -32'sd123456;   de[3]  = 32'hC7F1_2000;
        dv[4]  = 32'd16777217;   de[4]  = 32'h4B80_0000;
        dv[5]  = 32'd16777219;   de[5]  = 32'h4B80_0002;
        dv[6]  = 32'd16777221;   de[6]  = 32'h4B80_0002;
        dv[7]  = 32'h7FFF_FFFF;  de[7]  = 32'h4F00_0000;
        dv[8]  = 32'h01FF_FFFF;  de[8]  = 32'h4C00_0000;
        dv[9]  = 32'h8000_0000;  de[9]  = 32'hCF00_0000;
        dv[10] = 32'h8000_0001;  de[10] = 32'hCF00_0000;
        dv[11] = 32'd16777215;   de[11] = 32'h4B7F_FFFF;

        rstn  = 1'b0;
        bus.x = 32'd5;
        #2;
        check("reset_async", bus.y, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", bus.y, 32'd0);

        @(negedge clk);
        rstn = 1'b1;
        bus.x = 32'd0;
        in_q.push_back(32'd0);
        exp_q.push_back(32'd0);

        for (int i = 0; i < 12; i++) issue(dv[i], de[i]);
        drain();

        // async reset mid-stream
        @(negedge clk);
        bus.x = 32'd3;
        #1;
        rstn = 1'b0;
        #1;
        check("midreset_async", bus.y, 32'd0);
        @(posedge clk);
        #1;
        check("midreset_hold", bus.y, 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 4096; i++) begin
            logic [31:0] v;
            v = $urandom;
            case (i % 4)
                1: v = v >> (i % 31);
                2: v = -(v >> (i % 29));
                default: ;
            endcase
            issue(v, model(v));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=done");
        $fatal(1, "timeout");
    end

endmodule
